// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: decode-stage hazard and forwarding controller.
// Tracks the destination of every in-flight register writer for DEPTH stages
// after decode, resolves each source operand to the register file or to the
// youngest stage holding its producer, stalls on load results that are not
// yet available, and counts stall and forward cycles with saturation.
module fwd_scoreboard #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CW         = 16,
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [AW-1:0]         id_rs1,
    input  logic [AW-1:0]         id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [AW-1:0]         id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_is_load,
    input  logic [XLEN-1:0]       rf_rs1_data,
    input  logic [XLEN-1:0]       rf_rs2_data,
    input  logic [DEPTH*XLEN-1:0] stage_data,
    output logic                  stall,
    output logic [SW-1:0]         fwd_sel1,
    output logic [SW-1:0]         fwd_sel2,
    output logic [XLEN-1:0]       op1_data,
    output logic [XLEN-1:0]       op2_data,
    output logic [CW-1:0]         stall_cnt,
    output logic [CW-1:0]         fwd_cnt
);

    // One in-flight writer; a valid entry always means a register write.
    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          is_load;
    } entry_t;

    // Resolution of one source operand.
    typedef struct packed {
        logic            hazard;
        logic [SW-1:0]   sel;
        logic [XLEN-1:0] data;
    } res_t;

    // ent_q[1] is the instruction now in EX, ent_q[DEPTH] the oldest tracked.
    entry_t ent_q [1:DEPTH];

    res_t res1;
    res_t res2;
    logic issue;
    logic fwd_any;

    // Scan oldest to youngest so the youngest matching writer overrides.
    // An unready (load not yet at LOAD_STAGE) youngest match flags a hazard
    // and falls back to register-file data, which the stall then discards.
    function automatic res_t resolve(input logic [AW-1:0]   rs,
                                     input logic [XLEN-1:0] rf_data);
        res_t r;
        r.hazard = 1'b0;
        r.sel    = '0;
        r.data   = rf_data;
        if (rs == '0) begin
            r.data = '0;
        end else begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (ent_q[k].valid && ent_q[k].rd == rs) begin
                    if (!ent_q[k].is_load || k >= LOAD_STAGE) begin
                        r.hazard = 1'b0;
                        r.sel    = SW'(k);
                        r.data   = stage_data[k*XLEN-1 -: XLEN];
                    end else begin
                        r.hazard = 1'b1;
                        r.sel    = '0;
                        r.data   = rf_data;
                    end
                end
            end
        end
        return r;
    endfunction

    // Combinational operand resolution, stall and issue decisions.
    always_comb begin
        // NOTE: every always_comb output gets a value before any branch, so no path can leave a latch behind.
        res1    = resolve(id_rs1, rf_rs1_data);
        res2    = resolve(id_rs2, rf_rs2_data);
        stall   = id_valid && !flush &&
                  ((id_use_rs1 && res1.hazard) || (id_use_rs2 && res2.hazard));
        issue   = id_valid && id_regwrite && !stall && !flush;
        fwd_any = id_valid && !stall && !flush &&
                  ((id_use_rs1 && res1.sel != '0) || (id_use_rs2 && res2.sel != '0));
    end

    assign fwd_sel1 = res1.sel;
    assign fwd_sel2 = res2.sel;
    assign op1_data = res1.data;
    assign op2_data = res2.data;

    // Shift the writer scoreboard one stage per unfrozen cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every entry is reset, not just a pointer -- a stale valid bit would forward or stall on garbage.
            for (int k = 1; k <= DEPTH; k++) begin
                ent_q[k] <= '0;
            end
        end else if (!hold) begin
            // NOTE: non-blocking assignment makes each entry take its neighbour's old value regardless of loop order.
            for (int k = DEPTH; k >= 2; k--) begin
                ent_q[k] <= ent_q[k-1];
            end
            if (issue) begin
                ent_q[1] <= '{valid: 1'b1, rd: id_rd, is_load: id_is_load};
            end else begin
                ent_q[1] <= '0;
            end
        end
    end

    // Saturating stall and forward counters, frozen while hold is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!hold) begin
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (fwd_any && fwd_cnt != '1) begin
                fwd_cnt <= fwd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard (DEPTH=3, LOAD_STAGE=2, CW=4).
// Each decode cycle pushes its expected stall/select/data record onto a
// queue; the record is popped and compared once the outputs have settled.
module tb_fwd_scoreboard;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int LS    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  hold = 1'b0;
    logic                  flush = 1'b0;
    logic                  id_valid = 1'b0;
    logic [AW-1:0]         id_rs1 = '0;
    logic [AW-1:0]         id_rs2 = '0;
    logic                  id_use_rs1 = 1'b0;
    logic                  id_use_rs2 = 1'b0;
    logic [AW-1:0]         id_rd = '0;
    logic                  id_regwrite = 1'b0;
    logic                  id_is_load = 1'b0;
    logic [XLEN-1:0]       rf_rs1_data = '0;
    logic [XLEN-1:0]       rf_rs2_data = '0;
    logic [XLEN-1:0]       sd [1:DEPTH];
    logic [DEPTH*XLEN-1:0] stage_data;
    logic                  stall;
    logic [1:0]            fwd_sel1;
    logic [1:0]            fwd_sel2;
    logic [XLEN-1:0]       op1_data;
    logic [XLEN-1:0]       op2_data;
    logic [CW-1:0]         stall_cnt;
    logic [CW-1:0]         fwd_cnt;

    assign stage_data = {sd[3], sd[2], sd[1]};

    fwd_scoreboard #(
        .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LS), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .stage_data(stage_data),
        .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .op1_data(op1_data), .op2_data(op2_data),
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            stall;
        logic            s1_dc;
        logic [1:0]      s1;
        logic            s2_dc;
        logic [1:0]      s2;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   exp_sc = 0;
    int   exp_fc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Expected operand: forwarded stage value, zero for x0, else register file.
    function automatic logic [XLEN-1:0] exp_op(input int s, input logic [AW-1:0] rs,
                                               input logic [XLEN-1:0] rf);
        if (s > 0) return sd[s];
        if (rs == '0) return '0;
        return rf;
    endfunction

    // One decode cycle. e_s1/e_s2 = -1 marks an operand whose select is
    // don't-care because it sits on an unready load.
    task automatic step(input string tag, input logic v,
                        input logic [AW-1:0] rs1, input logic u1,
                        input logic [AW-1:0] rs2, input logic u2,
                        input logic [AW-1:0] rd, input logic rw, input logic ld,
                        input logic hd, input logic fl,
                        input logic e_stall, input int e_s1, input int e_s2);
        exp_t e;
        @(negedge clk);
        id_valid = v;  id_rs1 = rs1; id_use_rs1 = u1;
        id_rs2 = rs2;  id_use_rs2 = u2;
        id_rd = rd;    id_regwrite = rw; id_is_load = ld;
        hold = hd;     flush = fl;
        rf_rs1_data = 32'h1000_0000 | 32'(rs1);
        rf_rs2_data = 32'h2000_0000 | 32'(rs2);
        e.stall = e_stall;
        e.s1_dc = (e_s1 < 0);
        e.s1    = (e_s1 < 0) ? 2'd0 : 2'(e_s1);
        e.s2_dc = (e_s2 < 0);
        e.s2    = (e_s2 < 0) ? 2'd0 : 2'(e_s2);
        e.op1   = exp_op(e_s1, rs1, rf_rs1_data);
        e.op2   = exp_op(e_s2, rs2, rf_rs2_data);
        exp_q.push_back(e);
        #2;
        e = exp_q.pop_front();
        check({tag, ".stall"}, 64'(stall), 64'(e.stall));
        if (!e.s1_dc) begin
            check({tag, ".sel1"}, 64'(fwd_sel1), 64'(e.s1));
            check({tag, ".op1"}, 64'(op1_data), 64'(e.op1));
        end
        if (!e.s2_dc) begin
            check({tag, ".sel2"}, 64'(fwd_sel2), 64'(e.s2));
            check({tag, ".op2"}, 64'(op2_data), 64'(e.op2));
        end
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(exp_sc));
        check({tag, ".fwd_cnt"}, 64'(fwd_cnt), 64'(exp_fc));
        // Counter model for the coming rising edge.
        if (!hd) begin
            if (e_stall && exp_sc < CMAX) exp_sc++;
            if (v && !e_stall && !fl && ((u1 && e_s1 > 0) || (u2 && e_s2 > 0)) && exp_fc < CMAX)
                exp_fc++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH; i++)
            step("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        sd[1] = 32'hA000_0001;
        sd[2] = 32'hA000_0002;
        sd[3] = 32'hA000_0003;

        // Reset state: outputs follow the register file, counters clear.
        id_valid = 1; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 0; id_use_rs2 = 1;
        rf_rs1_data = 32'h1000_0005; rf_rs2_data = 32'h2000_0000;
        #3;
        check("rst.stall", 64'(stall), 64'(0));
        check("rst.sel1", 64'(fwd_sel1), 64'(0));
        check("rst.op1", 64'(op1_data), 64'h1000_0005);
        check("rst.op2_x0", 64'(op2_data), 64'(0));
        check("rst.stall_cnt", 64'(stall_cnt), 64'(0));
        check("rst.fwd_cnt", 64'(fwd_cnt), 64'(0));
        @(negedge clk);
        id_valid = 0;
        rst = 1;

        // ALU chain: x5 forwarded from EX, then MEM, then WB, then retired.
        step("alu.w5", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        sd[1] = 32'h1234;
        step("alu.r5_ex", 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 1, 0);
        sd[1] = 32'hA000_0001; sd[2] = 32'h1234;
        step("alu.r5_mem", 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 2, 1);
        step("alu.r5_wb", 0, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 3, 2);
        step("alu.retired", 0, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        drain();

        // Load-use: one stall, then forward from stage 2.
        step("ld.x7", 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0);
        step("ld.use_stall", 1, 0, 0, 7, 1, 8, 1, 0, 0, 0, 1, 0, -1);
        sd[2] = 32'hCAFE;
        step("ld.use_fwd", 1, 0, 0, 7, 1, 8, 1, 0, 0, 0, 0, 0, 2);
        drain();

        // Youngest writer wins; x0 never matches, even as a load target.
        step("pri.w3a", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        step("pri.w3b", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        step("pri.r3", 1, 3, 1, 3, 1, 0, 1, 1, 0, 0, 0, 1, 1);
        step("pri.x0", 1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 2);
        drain();

        // Flush during a load-use hazard: no stall, no entry for x10.
        step("fl.ld9", 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0);
        step("fl.flush", 1, 9, 1, 0, 0, 10, 1, 0, 0, 1, 0, -1, 0);
        step("fl.after", 1, 10, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 2);
        drain();

        // Hold freezes the pending load and the counters for 3 cycles.
        step("hd.ld11", 1, 0, 0, 0, 0, 11, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("hd.frozen", 1, 11, 1, 0, 0, 16, 1, 0, 1, 0, 1, -1, 0);
        step("hd.release", 1, 11, 1, 0, 0, 16, 1, 0, 0, 0, 1, -1, 0);
        step("hd.fwd", 1, 11, 1, 0, 0, 16, 1, 0, 0, 0, 0, 2, 0);
        drain();

        // Saturation: a self-dependent load stream stalls every other cycle.
        for (int i = 0; i < 40; i++) begin
            if (i == 0)         step("sat", 1, 12, 1, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0);
            else if (i % 2 == 1) step("sat", 1, 12, 1, 0, 0, 12, 1, 1, 0, 0, 1, -1, 0);
            else                step("sat", 1, 12, 1, 0, 0, 12, 1, 1, 0, 0, 0, 2, 0);
        end
        drain();
        check("sat.stall_cnt", 64'(stall_cnt), 64'(CMAX));
        check("sat.fwd_cnt", 64'(fwd_cnt), 64'(CMAX));

        // Asynchronous reset with three valid entries and a pending hazard.
        step("rr.w13", 1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0);
        step("rr.w14", 1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0);
        step("rr.ld15", 1, 0, 0, 0, 0, 15, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        id_valid = 1; id_rs1 = 15; id_use_rs1 = 1; id_rs2 = 13; id_use_rs2 = 1;
        id_rd = 0; id_regwrite = 0; id_is_load = 0;
        rf_rs1_data = 32'h1000_000F; rf_rs2_data = 32'h2000_000D;
        #1;
        check("rr.pre_stall", 64'(stall), 64'(1));
        check("rr.pre_sel2", 64'(fwd_sel2), 64'(3));
        rst = 0;
        #1;
        check("rr.stall", 64'(stall), 64'(0));
        check("rr.sel1", 64'(fwd_sel1), 64'(0));
        check("rr.sel2", 64'(fwd_sel2), 64'(0));
        check("rr.op1", 64'(op1_data), 64'h1000_000F);
        check("rr.op2", 64'(op2_data), 64'h2000_000D);
        check("rr.stall_cnt", 64'(stall_cnt), 64'(0));
        check("rr.fwd_cnt", 64'(fwd_cnt), 64'(0));
        rst = 1;
        exp_sc = 0;
        exp_fc = 0;
        step("rr.after", 1, 15, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined RISC-V core.
- Replaces the fixed EX/MEM forwarding flags with a DEPTH-entry in-flight writer scoreboard.
- Generates the decode-stage stall, per-operand forwarding selects and the muxed operand data.
- Keeps saturating performance counters for stalls and forwards.
- Sits between the decoder/register file and the ID/EX buffer.

Parameters:
- XLEN, 32, datapath width.
- AW, 5, register address width (2^AW architectural registers; register 0 hardwired to zero).
- DEPTH, 3, number of tracked stages after decode (1=EX, 2=MEM, 3=WB).
- LOAD_STAGE, 2, first stage index whose stage_data carries load results; must satisfy 1 <= LOAD_STAGE <= DEPTH.
- CW, 16, performance counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- hold  in  1  global pipeline freeze (memory wait).
- flush  in  1  branch taken; kills the instruction currently in decode.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1, id_rs2  in  AW  source register addresses.
- id_use_rs1, id_use_rs2  in  1  the instruction reads this source.
- id_rd  in  AW  destination register.
- id_regwrite  in  1  the instruction writes id_rd.
- id_is_load  in  1  the instruction is a load.
- rf_rs1_data, rf_rs2_data  in  XLEN  register file read data.
- stage_data  in  DEPTH*XLEN  result of stage k on bits [k*XLEN-1:(k-1)*XLEN].
- stall  out  1  hold the PC and IF/ID; insert a bubble into EX.
- fwd_sel1, fwd_sel2  out  $clog2(DEPTH+1)  0 = register file, k = stage k.
- op1_data, op2_data  out  XLEN  resolved operand values.
- stall_cnt  out  CW  saturating count of stall cycles.
- fwd_cnt  out  CW  saturating count of cycles with at least one nonzero select.

Behaviour:
- State:
  - Entry[k], k = 1..DEPTH, each holding {valid, rd, is_load}.
  - stall_cnt and fwd_cnt.
- Reset:
  - Applies immediately on rst = 0, regardless of clk.
  - All entries become invalid and both counters go to 0.
  - This gives stall = 0, fwd_sel* = 0 and op*_data = rf data (or 0 for register 0) while in reset.
  - Reset mid-stream discards every in-flight entry.
- Match for operand n:
  - Entry k matches when valid, rd == id_rsn and rd != 0.
  - The youngest match (smallest k) wins.
  - Entries are created only when id_regwrite = 1, so a valid entry always implies a register write.
- Ready rule: a matching entry is ready when !is_load or k >= LOAD_STAGE.
- Operand resolution (combinational):
  - id_rsn == 0 gives sel 0 and data 0.
  - No match gives sel 0 and the rf data.
  - A ready match gives sel k and stage_data[k].
  - An unready match gives a hazard.
- Stall:
  - stall = id_valid & !flush & ((id_use_rs1 & hazard1) | (id_use_rs2 & hazard2)).
  - Unused operands never stall, though their sel/data are still computed.
- Advance (rising edge, only when hold = 0):
  - Entry[k+1] <= Entry[k]; Entry[DEPTH] retires.
  - Entry[1] <= {1, id_rd, id_is_load} if id_valid & id_regwrite & !stall & !flush; otherwise Entry[1] is invalid.
  - The register file writes the retiring result at that same edge, so a read in the next cycle sees it.
- Hold = 1: no entry moves and no counter increments; outputs continue to be recomputed combinationally.
- Simultaneous flush and hazard: flush wins; stall = 0 and the bubble enters Entry[1].
- Counters (only when hold = 0):
  - stall_cnt increments when stall = 1.
  - fwd_cnt increments when id_valid & !stall & !flush and either used operand has a nonzero sel.
  - Both saturate at 2^CW - 1 and do not wrap.
- Latency:
  - Zero-cycle combinational path from decode inputs to stall, sel and data.
  - One-cycle path from issue to Entry[1].
- Load-use:
  - A dependent instruction immediately following a load stalls LOAD_STAGE - 1 cycles, then forwards from stage LOAD_STAGE.

Test Plan:
- ALU chain, defaults: issue add x5 (id_rd=5, regwrite); next cycle issue a read of rs1=5 with stage_data[1]=0x1234 -> stall=0, fwd_sel1=1, op1_data=0x1234; the cycle after, with stage_data[2]=0x1234 -> fwd_sel1=2.
- Load-use, LOAD_STAGE=2: issue a load of x7; next instruction reads rs2=7 -> stall=1 for exactly one cycle (Entry[1] gets a bubble), then fwd_sel2=2 with op2_data=stage_data[2]=0xCAFE; stall_cnt=1.
- Priority and x0: two back-to-back writes to x3 followed by a read of x3 -> fwd_sel1=1 (youngest); a read of rs1=0 with an in-flight write to rd=0 -> sel 0, op1_data=0, no stall.
- Flush and hold: flush during a load-use hazard -> stall=0 and no entry created; hold=1 for 3 cycles with a pending load -> entries frozen, counters unchanged, stall persists until hold drops and the load reaches stage 2.
- Counter saturation, CW=4: force 20 stall cycles -> stall_cnt reaches 15 and stays at 15.
- Reset mid-operation: rst=0 asynchronously with three valid entries -> immediately stall=0 and all sels 0; after release, a read of the previously pending register returns the rf data.
